// File: rtl/alu_pkg.sv
// Shared definitions for the ALU output path: select codes, buffer occupancy
// encoding and the layout of one buffered ALU result.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam int ALU_W    = 32;
    localparam int ALU_RD_W = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    // One buffered result at the default widths; select codes above ALU_OR are illegal.
    typedef struct packed {
        logic [ALU_W-1:0]    result;
        logic                zero;
        logic [ALU_RD_W-1:0] rd;
        logic                branch;
        logic                illegal;
    } alu_entry_t;

    function automatic logic isIllegalSel(input logic [2:0] sel);
        return sel > ALU_OR;
    endfunction

endpackage

// File: rtl/alu_buf_entry.sv
// One load-enabled storage slot of the ALU output buffer (result, zero, rd,
// branch, illegal), cleared by the asynchronous reset.
module alu_buf_entry #(
    parameter int n    = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [n-1:0]    i_result,
    input  logic            i_zero,
    input  logic [RD_W-1:0] i_rd,
    input  logic            i_branch,
    input  logic            i_illegal,
    output logic [n-1:0]    o_result,
    output logic            o_zero,
    output logic [RD_W-1:0] o_rd,
    output logic            o_branch,
    output logic            o_illegal
);

    logic [n-1:0]    r_result;
    logic            r_zero;
    logic [RD_W-1:0] r_rd;
    logic            r_branch;
    logic            r_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_rd      <= '0;
            r_branch  <= 1'b0;
            r_illegal <= 1'b0;
        end else if (i_load) begin
            r_result  <= i_result;
            r_zero    <= i_zero;
            r_rd      <= i_rd;
            r_branch  <= i_branch;
            r_illegal <= i_illegal;
        end
    end

    assign o_result  = r_result;
    assign o_zero    = r_zero;
    assign o_rd      = r_rd;
    assign o_branch  = r_branch;
    assign o_illegal = r_illegal;

endmodule

// File: rtl/alu_out_buffer.sv
// Two-entry registered skid buffer behind the ALU with branch resolution.
// Optional downstream stall counter enabled by `define ALU_BUF_STALL_CNT_EN.
module alu_out_buffer
    import alu_pkg::*;
#(
    parameter int n    = ALU_W,
    parameter int RD_W = ALU_RD_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [n-1:0]    in_result,
    input  logic            in_zero,
    input  logic [2:0]      in_sel,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_branch,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [n-1:0]    out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_take_branch,
    output logic            out_illegal,
    output logic [31:0]     stall_cnt
);

    buf_state_e r_state;
    buf_state_e w_next_state;
    logic       r_in_ready;

    logic       w_push;
    logic       w_pop;
    logic       w_load_h;
    logic       w_load_s;
    logic       w_h_from_s;

    logic [n-1:0]    w_h_result, w_s_result, w_h_d_result;
    logic            w_h_zero,   w_s_zero,   w_h_d_zero;
    logic [RD_W-1:0] w_h_rd,     w_s_rd,     w_h_d_rd;
    logic            w_h_branch, w_s_branch, w_h_d_branch;
    logic            w_h_illegal, w_s_illegal, w_h_d_illegal;
    logic            w_in_illegal;

    assign w_push       = in_valid && r_in_ready;
    assign w_pop        = out_valid && out_ready;
    assign w_in_illegal = isIllegalSel(in_sel);

    always_comb begin
        w_next_state = r_state;
        w_load_h     = 1'b0;
        w_load_s     = 1'b0;
        w_h_from_s   = 1'b0;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_load_h     = 1'b1;
                        w_next_state = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_load_h = 1'b1;
                    end else if (w_push) begin
                        w_load_s     = 1'b1;
                        w_next_state = ST_TWO;
                    end else if (w_pop) begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        w_load_h     = 1'b1;
                        w_h_from_s   = 1'b1;
                        w_next_state = ST_ONE;
                    end
                end
                default: w_next_state = ST_EMPTY;
            endcase
        end
    end

    // in_ready is precomputed from the next state so it never depends on out_ready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_TWO);
        end
    end

    assign w_h_d_result  = w_h_from_s ? w_s_result  : in_result;
    assign w_h_d_zero    = w_h_from_s ? w_s_zero    : in_zero;
    assign w_h_d_rd      = w_h_from_s ? w_s_rd      : in_rd;
    assign w_h_d_branch  = w_h_from_s ? w_s_branch  : in_branch;
    assign w_h_d_illegal = w_h_from_s ? w_s_illegal : w_in_illegal;

    alu_buf_entry #(.n(n), .RD_W(RD_W)) u_head (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load_h),
        .i_result  (w_h_d_result),
        .i_zero    (w_h_d_zero),
        .i_rd      (w_h_d_rd),
        .i_branch  (w_h_d_branch),
        .i_illegal (w_h_d_illegal),
        .o_result  (w_h_result),
        .o_zero    (w_h_zero),
        .o_rd      (w_h_rd),
        .o_branch  (w_h_branch),
        .o_illegal (w_h_illegal)
    );

    alu_buf_entry #(.n(n), .RD_W(RD_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load_s),
        .i_result  (in_result),
        .i_zero    (in_zero),
        .i_rd      (in_rd),
        .i_branch  (in_branch),
        .i_illegal (w_in_illegal),
        .o_result  (w_s_result),
        .o_zero    (w_s_zero),
        .o_rd      (w_s_rd),
        .o_branch  (w_s_branch),
        .o_illegal (w_s_illegal)
    );

    assign in_ready        = r_in_ready;
    assign out_valid       = (r_state != ST_EMPTY);
    assign out_result      = w_h_result;
    assign out_rd          = w_h_rd;
    assign out_take_branch = w_h_branch && w_h_zero;
    assign out_illegal     = w_h_illegal;

`ifdef ALU_BUF_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of cycles the head is held by downstream; flush leaves it intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_alu_out_buffer.sv
// Directed self-checking bench for alu_out_buffer with hand-computed expectations.
module tb_alu_out_buffer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_zero;
    logic [2:0]  in_sel;
    logic [4:0]  in_rd;
    logic        in_branch;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_take_branch;
    logic        out_illegal;
    logic [31:0] stall_cnt;

    int vectorCount = 0;
    int missCount   = 0;

    alu_out_buffer #(.n(32), .RD_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_result       (in_result),
        .in_zero         (in_zero),
        .in_sel          (in_sel),
        .in_rd           (in_rd),
        .in_branch       (in_branch),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .out_rd          (out_rd),
        .out_take_branch (out_take_branch),
        .out_illegal     (out_illegal),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] result, input logic [4:0] rd,
                                 input logic [2:0] sel, input logic branch, input logic zero);
        in_valid  = valid;
        in_result = result;
        in_rd     = rd;
        in_sel    = sel;
        in_branch = branch;
        in_zero   = zero;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        checkOutput({tag, "_out_result"}, out_result, 32'd0);
        checkOutput({tag, "_out_rd"}, {27'd0, out_rd}, 32'd0);
        checkOutput({tag, "_take_branch"}, {31'd0, out_take_branch}, 32'd0);
        checkOutput({tag, "_illegal"}, {31'd0, out_illegal}, 32'd0);
        checkOutput({tag, "_stall_cnt"}, stall_cnt, 32'd0);
    endtask

    logic [31:0] expStall;

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b0, 32'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        #12;
        checkResetValues("reset");
        step();
        rst = 1'b0;

        // Single result through an empty buffer
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'h0000_0005, 5'd3, 3'b000, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 32'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        checkOutput("t1_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("t1_result", out_result, 32'h5);
        checkOutput("t1_rd", {27'd0, out_rd}, 32'd3);
        step();
        checkOutput("t1_drained", {31'd0, out_valid}, 32'd0);

        // Fill to TWO while stalled, then drain in order
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'hA, 5'd1, 3'b001, 1'b0, 1'b0);
        step();
        checkOutput("t2_ready_one", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b1, 32'hB, 5'd2, 3'b010, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 32'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        checkOutput("t2_ready_full", {31'd0, in_ready}, 32'd0);
        checkOutput("t2_head_a", out_result, 32'hA);
        out_ready = 1'b1;
        step();
        checkOutput("t2_head_b", out_result, 32'hB);
        checkOutput("t2_rd_b", {27'd0, out_rd}, 32'd2);
        checkOutput("t2_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        checkOutput("t2_drained", {31'd0, out_valid}, 32'd0);

        // Branch resolution, second push overlaps the pop of the first
        applyStimulus(1'b1, 32'h0, 5'd4, 3'b001, 1'b1, 1'b1);
        step();
        checkOutput("t3_taken", {31'd0, out_take_branch}, 32'd1);
        applyStimulus(1'b1, 32'h1, 5'd5, 3'b001, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 32'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        checkOutput("t3_valid2", {31'd0, out_valid}, 32'd1);
        checkOutput("t3_not_taken", {31'd0, out_take_branch}, 32'd0);
        checkOutput("t3_result2", out_result, 32'h1);
        step();
        checkOutput("t3_drained", {31'd0, out_valid}, 32'd0);

        // Illegal select is flagged but still delivered exactly once
        applyStimulus(1'b1, 32'h77, 5'd7, 3'b101, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 32'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        checkOutput("t4_illegal", {31'd0, out_illegal}, 32'd1);
        checkOutput("t4_result", out_result, 32'h77);
        checkOutput("t4_valid", {31'd0, out_valid}, 32'd1);
        step();
        checkOutput("t4_once", {31'd0, out_valid}, 32'd0);

        // Flush in TWO together with a push
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'hC, 5'd8, 3'b000, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'hD, 5'd9, 3'b000, 1'b0, 1'b0);
        step();
        flush = 1'b1;
        applyStimulus(1'b1, 32'hE, 5'd10, 3'b000, 1'b0, 1'b0);
        step();
        flush = 1'b0;
        applyStimulus(1'b0, 32'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        checkOutput("t5_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t5_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step();
        checkOutput("t5_no_stale", {31'd0, out_valid}, 32'd0);

        // Stall counter from a clean reset, flush keeps it, async reset clears everything
        rst = 1'b1;
        #2;
        checkResetValues("rst_pulse");
        rst = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h99, 5'd11, 3'b000, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 32'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step();
`ifdef ALU_BUF_STALL_CNT_EN
        expStall = 32'd7;
`else
        expStall = 32'd0;
`endif
        checkOutput("t6_stall7", stall_cnt, expStall);
        checkOutput("t6_head", out_result, 32'h99);
        flush = 1'b1;
        step();
        flush = 1'b0;
`ifdef ALU_BUF_STALL_CNT_EN
        expStall = 32'd8;
`else
        expStall = 32'd0;
`endif
        checkOutput("t6_flush_keeps", stall_cnt, expStall);
        checkOutput("t6_flush_empty", {31'd0, out_valid}, 32'd0);
        applyStimulus(1'b1, 32'h55, 5'd12, 3'b000, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 32'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        checkOutput("t6_pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("mid_rst");
        step();
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
